// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the memory port arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ       = 4;
  localparam int unsigned SEL_W         = 2;
  localparam int unsigned TIMEOUT_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Binary requester index to one-hot grant/done vector.
  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    return NUM_REQ'(1) << sel;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory-side signal bundle of the memory port arbiter.
interface mem_port_arbiter_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               mem_ready;
  logic [SEL_W-1:0]   select;
  logic [NUM_REQ-1:0] grant;
  logic               mem_valid;
  logic [NUM_REQ-1:0] done;
  logic               timeout_err;

  // Arbiter side.
  modport slave (
    input  req, mem_ready,
    output select, grant, mem_valid, done, timeout_err
  );

  // Requester / memory side.
  modport master (
    output req, mem_ready,
    input  select, grant, mem_valid, done, timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first set request scanning upward from last_grant+1 with wrap.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last_grant,
  output logic               found,
  output logic [SEL_W-1:0]   idx,
  output logic [NUM_REQ-1:0] one_hot
);

  logic [SEL_W-1:0] cand;

  // Priority scan; the 2-bit add wraps naturally, k=NUM_REQ revisits last_grant itself.
  always_comb begin
    found   = 1'b0;
    idx     = '0;
    cand    = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = SEL_W'(last_grant + SEL_W'(k));
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    one_hot = found ? sel_to_onehot(idx) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared 32-bit memory port (4 requesters).
// Optional build macro ARB_TIMEOUT_EN: abort a transfer stuck in BUSY for
// TIMEOUT_CYCLES cycles and pulse timeout_err.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  // Reject out-of-range timeout limits at elaboration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

`ifdef ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] TMO_LIMIT = TIMEOUT_CNT_W'(TIMEOUT_CYCLES);
  logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;
  logic                     terr_q, terr_d;
`endif

  rr_pick u_pick (
    .req        (bus.req),
    .last_grant (last_q),
    .found      (pick_found),
    .idx        (pick_idx),
    .one_hot    (pick_onehot)
  );

  // State and output registers; reset leaves requester 0 at top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      select_q <= '0;
      last_q   <= SEL_W'(NUM_REQ - 1);
      grant_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= '0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
`endif
    end
  end

  // Next state: arbitrate in IDLE, hold the grant in BUSY until completion (or abort).
  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    last_d   = last_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    done_d   = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    terr_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        valid_d = 1'b0;
        if (pick_found) begin
          state_d  = BUSY;
          select_d = pick_idx;
          grant_d  = pick_onehot;
          valid_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          state_d = IDLE;
          done_d  = sel_to_onehot(select_q);
          grant_d = '0;
          valid_d = 1'b0;
          last_d  = select_q;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + TIMEOUT_CNT_W'(1);
          if (cnt_d == TMO_LIMIT) begin
            state_d = IDLE;
            terr_d  = 1'b1;
            grant_d = '0;
            valid_d = 1'b0;
            last_d  = select_q;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.select    = select_q;
  assign bus.grant     = grant_q;
  assign bus.mem_valid = valid_q;
  assign bus.done      = done_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  localparam int unsigned TB_TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port, who was served last, and this cycle's pulses.
  bit         m_busy;
  int         m_sel;
  int         m_last;
  logic [3:0] m_done;
  logic       m_terr;
  int         m_cnt;

  logic [3:0] order_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grant"},  32'(bus.grant),       m_busy ? (32'(1) << m_sel) : 32'(0));
    chk({tag, ".select"}, 32'(bus.select),      32'(m_sel));
    chk({tag, ".valid"},  32'(bus.mem_valid),   32'(m_busy));
    chk({tag, ".done"},   32'(bus.done),        32'(m_done));
    chk({tag, ".terr"},   32'(bus.timeout_err), 32'(m_terr));
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_last = 3;
    m_done = '0;
    m_terr = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock of the spec's rules: arbitrate when idle, finish on ready when busy.
  task automatic model_clock(input logic [3:0] r, input logic m);
    int c;
    m_done = '0;
    m_terr = 1'b0;
    if (!m_busy) begin
      if (r != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (r[c]) begin
            m_sel = c;
            break;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (m) begin
      m_done = 4'(1 << m_sel);
      m_busy = 1'b0;
      m_last = m_sel;
    end
`ifdef ARB_TIMEOUT_EN
    else begin
      m_cnt++;
      if (m_cnt == int'(TB_TO)) begin
        m_terr = 1'b1;
        m_busy = 1'b0;
        m_last = m_sel;
      end
    end
`endif
  endtask

  task automatic cycle(input logic [3:0] r, input logic m, input string tag);
    bus.req       = r;
    bus.mem_ready = m;
    @(posedge clk);
    model_clock(r, m);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    bus.req       = '0;
    bus.mem_ready = 1'b0;
    rst_n         = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // No requests: everything stays quiet.
    for (int i = 0; i < 5; i++) cycle(4'b0000, 1'b0, "idle");

    // All requesting, memory always ready: strict rotation 0,1,2,3,0.
    for (int i = 0; i < 10; i++) begin
      cycle(4'b1111, 1'b1, "rr_all");
      if (bus.mem_valid) order_q.push_back(bus.grant);
    end
    chk("rr_order.count", 32'(order_q.size()), 32'd5);
    if (order_q.size() == 5) begin
      chk("rr_order.0", 32'(order_q[0]), 32'h1);
      chk("rr_order.1", 32'(order_q[1]), 32'h2);
      chk("rr_order.2", 32'(order_q[2]), 32'h4);
      chk("rr_order.3", 32'(order_q[3]), 32'h8);
      chk("rr_order.4", 32'(order_q[4]), 32'h1);
    end
    cycle(4'b0000, 1'b0, "rr_drain");

    // Single requester 2, three BUSY cycles before completion.
    cycle(4'b0100, 1'b0, "req2_grant");
    chk("req2.select", 32'(bus.select), 32'd2);
    cycle(4'b0100, 1'b0, "req2_busy");
    cycle(4'b0100, 1'b0, "req2_busy");
    cycle(4'b0100, 1'b1, "req2_done");
    chk("req2.done", 32'(bus.done), 32'h4);
    cycle(4'b0000, 1'b0, "req2_after");

    // Requester 1 drops its request mid-transfer; it still completes.
    cycle(4'b0010, 1'b0, "drop_grant");
    cycle(4'b0000, 1'b0, "drop_busy");
    cycle(4'b0000, 1'b0, "drop_busy");
    cycle(4'b0000, 1'b1, "drop_done");
    chk("drop.done", 32'(bus.done), 32'h2);

    // Memory ready while idle must be ignored.
    cycle(4'b0000, 1'b1, "idle_ready");
    cycle(4'b0000, 1'b1, "idle_ready");

    // Asynchronous reset in the middle of a transfer to requester 3.
    cycle(4'b1000, 1'b0, "rst_grant");
    cycle(4'b1000, 1'b0, "rst_busy");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1001, 1'b0, "post_rst_grant");
    chk("post_rst.winner", 32'(bus.grant), 32'h1);
    cycle(4'b1001, 1'b1, "post_rst_done");
    cycle(4'b0000, 1'b0, "post_rst_idle");

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort after TB_TO BUSY cycles, next grant rotates.
    for (int i = 0; i < 6; i++) cycle(4'b0011, 1'b0, "timeout");
    cycle(4'b0011, 1'b1, "timeout_recover");
    cycle(4'b0000, 1'b0, "timeout_idle");
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
